// File: rtl/block_state_store_pkg.sv
// block_state_store_pkg: shared wall geometry, fill pattern and FSM state type
package block_state_store_pkg;
  localparam int BLOCKS_PER_ROW = 13;
  localparam int NUM_ROWS = 16;
  localparam int ROW_IDX_W = 4;
  localparam int COL_IDX_W = 4;
  localparam logic [BLOCKS_PER_ROW-1:0] FILL_PATTERN = 13'h1FFF;
  typedef enum logic {FILL, IDLE} state_t;
endpackage

// File: rtl/block_state_store_popcount13.sv
// popcount13: number of set bits in a 13-bit row (in: row[12:0], out: count[3:0])
module popcount13 (
  input  logic [12:0] row,
  output logic [3:0]  count
);
  always_comb begin
    count = '0;
    for (int i = 0; i < 13; i++) count = count + 4'(row[i]);
  end
endmodule

// File: rtl/block_state_store.sv
// block_state_store: breakout wall storage; in: clk nRst new_frame go_next_line level_load hit_valid/row/col; out: hit_ready hit_resp_valid hit_present block_line_state blocks_remaining wall_cleared
module block_state_store
  import block_state_store_pkg::*;
(
  input  logic                      clk,
  input  logic                      nRst,
  input  logic                      new_frame,
  input  logic                      go_next_line,
  input  logic                      level_load,
  input  logic                      hit_valid,
  input  logic [ROW_IDX_W-1:0]      hit_row,
  input  logic [COL_IDX_W-1:0]      hit_col,
  output logic                      hit_ready,
  output logic                      hit_resp_valid,
  output logic                      hit_present,
  output logic [BLOCKS_PER_ROW-1:0] block_line_state,
  output logic [7:0]                blocks_remaining,
  output logic                      wall_cleared
);
  state_t state, state_n;
  logic [ROW_IDX_W-1:0] fill_row, fill_row_n, row_idx, row_idx_n, wr_row;
  logic [BLOCKS_PER_ROW-1:0] rows [NUM_ROWS];
  logic [BLOCKS_PER_ROW-1:0] hit_data, wr_data;
  logic [7:0] count_n;
  logic [3:0] fill_pop;
  logic accept, hit_ok, wr_en;
  popcount13 u_pop (.row(FILL_PATTERN), .count(fill_pop));
  always_comb begin
    hit_ready = state == IDLE;
    accept = hit_valid && hit_ready;
    hit_data = rows[hit_row];
    hit_ok = accept && !level_load && 32'(hit_row) < NUM_ROWS && 32'(hit_col) < BLOCKS_PER_ROW && hit_data[hit_col];
    wr_en = state == FILL ? !level_load : hit_ok;
    wr_row = state == FILL ? fill_row : hit_row;
    wr_data = state == FILL ? FILL_PATTERN : hit_data & ~(BLOCKS_PER_ROW'(1) << hit_col);
    state_n = level_load ? FILL : (state == FILL && fill_row == ROW_IDX_W'(NUM_ROWS - 1)) ? IDLE : state;
    fill_row_n = (level_load || state == IDLE) ? '0 : fill_row + ROW_IDX_W'(1);
    count_n = level_load ? '0 :
              state == FILL ? blocks_remaining + 8'(fill_pop) :
              (hit_ok && blocks_remaining != '0) ? blocks_remaining - 8'd1 : blocks_remaining;
    row_idx_n = new_frame ? '0 :
                (go_next_line && row_idx != ROW_IDX_W'(NUM_ROWS - 1)) ? row_idx + ROW_IDX_W'(1) : row_idx;
    wall_cleared = blocks_remaining == '0 && state == IDLE;
  end
  always_ff @(posedge clk) begin
    if (!nRst) begin
      state <= FILL;
      fill_row <= '0;
      row_idx <= '0;
      block_line_state <= '0;
      blocks_remaining <= '0;
      hit_resp_valid <= 1'b0;
      hit_present <= 1'b0;
    end else begin
      state <= state_n;
      fill_row <= fill_row_n;
      row_idx <= row_idx_n;
      // bypass this cycle's write so the displayed row never lags storage
      block_line_state <= (wr_en && wr_row == row_idx_n) ? wr_data : rows[row_idx_n];
      blocks_remaining <= count_n;
      hit_resp_valid <= accept;
      hit_present <= hit_ok;
    end
  end
  always_ff @(posedge clk)
    if (nRst && wr_en) rows[wr_row] <= wr_data;
endmodule

// File: tb/tb_block_state_store.sv
// tb_block_state_store: directed stimulus with a behavioural wall model checked every cycle
module tb_block_state_store;
  logic clk = 0, nRst = 0, new_frame = 0, go_next_line = 0, level_load = 0, hit_valid = 0;
  logic [3:0] hit_row = 0, hit_col = 0;
  logic hit_ready, hit_resp_valid, hit_present, wall_cleared;
  logic [12:0] block_line_state;
  logic [7:0] blocks_remaining;
  int checks = 0, errors = 0;
  bit [12:0] m_rows [16];
  bit m_known [16];
  bit m_valid = 0, m_filling, m_rv, m_rp, m_line_known;
  bit [12:0] m_line;
  int m_fill, m_count, m_row;
  always #5 clk = ~clk;
  block_state_store dut (
    .clk(clk), .nRst(nRst), .new_frame(new_frame), .go_next_line(go_next_line),
    .level_load(level_load), .hit_valid(hit_valid), .hit_row(hit_row), .hit_col(hit_col),
    .hit_ready(hit_ready), .hit_resp_valid(hit_resp_valid), .hit_present(hit_present),
    .block_line_state(block_line_state), .blocks_remaining(blocks_remaining),
    .wall_cleared(wall_cleared)
  );
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  always @(posedge clk) begin
    m_valid = 1;
    if (!nRst) begin
      m_filling = 1; m_fill = 0; m_count = 0; m_row = 0;
      m_line = 0; m_line_known = 1; m_rv = 0; m_rp = 0;
      for (int i = 0; i < 16; i++) m_known[i] = 0;
    end else begin
      m_rv = hit_valid && !m_filling;
      m_rp = 0;
      if (level_load) begin
        m_filling = 1; m_fill = 0; m_count = 0;
      end else if (m_filling) begin
        m_rows[m_fill] = 13'h1FFF;
        m_known[m_fill] = 1;
        m_count += 13;
        m_fill++;
        if (m_fill == 16) m_filling = 0;
      end else if (m_rv && hit_col < 13 && m_rows[hit_row][hit_col]) begin
        m_rows[hit_row][hit_col] = 0;
        if (m_count > 0) m_count--;
        m_rp = 1;
      end
      m_row = new_frame ? 0 : go_next_line ? (m_row < 15 ? m_row + 1 : 15) : m_row;
      m_line = m_rows[m_row];
      m_line_known = m_known[m_row];
    end
  end
  always @(negedge clk) if (m_valid) begin
    chk("ready", int'(hit_ready), int'(!m_filling));
    chk("resp_valid", int'(hit_resp_valid), int'(m_rv));
    chk("present", int'(hit_present), int'(m_rp));
    chk("remaining", int'(blocks_remaining), m_count);
    chk("cleared", int'(wall_cleared), int'(m_count == 0 && !m_filling));
    if (m_line_known) chk("line", int'(block_line_state), int'(m_line));
  end
  task automatic step(int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic hit(int r, int c);
    hit_valid = 1; hit_row = 4'(r); hit_col = 4'(c);
    step();
    hit_valid = 0;
  endtask
  task automatic pulses(int n);
    go_next_line = 1;
    step(n);
    go_next_line = 0;
  endtask
  initial begin
    int miss;
    step(2);
    chk("rst_ready", int'(hit_ready), 0);
    chk("rst_remaining", int'(blocks_remaining), 0);
    chk("rst_line", int'(block_line_state), 0);
    chk("rst_cleared", int'(wall_cleared), 0);
    nRst = 1;
    step(15);
    chk("fill15_ready", int'(hit_ready), 0);
    step();
    chk("fill16_ready", int'(hit_ready), 1);
    chk("fill16_remaining", int'(blocks_remaining), 208);
    chk("fill16_cleared", int'(wall_cleared), 0);
    new_frame = 1; step(); new_frame = 0;
    pulses(3);
    chk("row3_idx", int'(dut.row_idx), 3);
    chk("row3_line", int'(block_line_state), 'h1FFF);
    hit(3, 5);
    chk("hit35_valid", int'(hit_resp_valid), 1);
    chk("hit35_present", int'(hit_present), 1);
    chk("hit35_line", int'(block_line_state), 'h1FDF);
    chk("hit35_remaining", int'(blocks_remaining), 207);
    hit(3, 5);
    chk("rehit_present", int'(hit_present), 0);
    hit(2, 13);
    chk("oob_present", int'(hit_present), 0);
    chk("oob_remaining", int'(blocks_remaining), 207);
    pulses(20);
    chk("sat_idx", int'(dut.row_idx), 15);
    level_load = 1; step(); level_load = 0;
    step(16);
    chk("reload_remaining", int'(blocks_remaining), 208);
    miss = 0;
    hit_valid = 1;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 13; c++) begin
        hit_row = 4'(r); hit_col = 4'(c);
        step();
        if (hit_present !== 1'b1) miss++;
      end
    hit_valid = 0;
    chk("b2b_misses", miss, 0);
    chk("b2b_remaining", int'(blocks_remaining), 0);
    chk("b2b_cleared", int'(wall_cleared), 1);
    hit(0, 0);
    chk("empty_present", int'(hit_present), 0);
    chk("empty_remaining", int'(blocks_remaining), 0);
    level_load = 1; step(); level_load = 0;
    step(16);
    hit_valid = 1; hit_row = 0; hit_col = 0; level_load = 1;
    step();
    hit_valid = 0; level_load = 0;
    chk("drop_valid", int'(hit_resp_valid), 1);
    chk("drop_present", int'(hit_present), 0);
    chk("drop_remaining", int'(blocks_remaining), 0);
    chk("drop_ready", int'(hit_ready), 0);
    step(4);
    nRst = 0; step(); nRst = 1;
    step(5);
    level_load = 1; step(); level_load = 0;
    chk("restart_remaining", int'(blocks_remaining), 0);
    step(16);
    chk("final_remaining", int'(blocks_remaining), 208);
    chk("final_ready", int'(hit_ready), 1);
    hit(0, 0);
    chk("final_present", int'(hit_present), 1);
    step(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
